// File: rtl/eth_rx_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// eth_rx_dispatch_pkg
// Shared types for the receive-side packet dispatcher.
//   state_e     : dispatcher FSM states (IDLE / PASS / DISCARD)
//   word_t      : one bus word {data, empty, sop, eop, tuser} at the default
//                 widths; the datapath itself uses flat vectors of
//                 word_width() bits in the same field order so that
//                 non-default parameters keep working.
// ---------------------------------------------------------------------------
package eth_rx_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PASS    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    localparam int WORD_DATA_W  = 64;
    localparam int WORD_EMPTY_W = 3;
    localparam int WORD_TUSER_W = 32;

    typedef logic [WORD_DATA_W-1:0]  word_data_t;
    typedef logic [WORD_EMPTY_W-1:0] word_empty_t;
    typedef logic [WORD_TUSER_W-1:0] word_tuser_t;

    typedef struct packed {
        word_data_t  data;
        word_empty_t empty;
        logic        sop;
        logic        eop;
        word_tuser_t tuser;
    } word_t;

    // Flat word width: data + empty + sop + eop + tuser.
    function automatic int word_width(input int dw, input int ew, input int tw);
        return dw + ew + tw + 2;
    endfunction

endpackage

// File: rtl/eth_pkt_out_reg.sv
// ---------------------------------------------------------------------------
// eth_pkt_out_reg
// Single-entry output register with valid/ready for one dispatch direction.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   i_load         : capture i_word (only asserted when o_can_take is high)
//   i_word         : flat word to capture
//   i_ready        : downstream ready
//   o_val, o_word  : registered valid and word
//   o_can_take     : register is empty or being drained this cycle
// ---------------------------------------------------------------------------
module eth_pkt_out_reg #(
    parameter int WORD_W = 101
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_ready,
    output logic              o_val,
    output logic [WORD_W-1:0] o_word,
    output logic              o_can_take
);

    logic              r_val;
    logic [WORD_W-1:0] r_word;

    assign o_can_take = ~r_val | i_ready;
    assign o_val      = r_val;
    assign o_word     = r_word;

    // A load may coincide with a drain; the new word simply replaces it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_val  <= 1'b0;
            r_word <= '0;
        end else if (i_load) begin
            r_val  <= 1'b1;
            r_word <= i_word;
        end else if (i_ready) begin
            r_val  <= 1'b0;
        end
    end

endmodule

// File: rtl/eth_rx_dispatch.sv
// ---------------------------------------------------------------------------
// eth_rx_dispatch
// Steers each received packet to one or more of DIR_CNT directions using a
// per-packet direction mask sampled at sop, with per-direction lossy mode,
// a default direction and per-direction delivered/dropped packet counters.
//   clk_i, rst_n_i            : clock, asynchronous active-low reset
//   pkt_*_i, pkt_ready_o      : input word stream
//   dir_mask_i, lossy_mask_i  : per-packet targets / lossy enables (at sop)
//   cnt_clr_i                 : synchronous clear of all counters
//   pkt_*_o, pkt_ready_i      : DIR_CNT output streams, flat-packed per dir
//   pkt_cnt_o, drop_cnt_o     : per-direction counters, flat-packed
//   orphan_o                  : pulse when a non-sop word is dropped in IDLE
// ---------------------------------------------------------------------------
module eth_rx_dispatch
    import eth_rx_dispatch_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int TUSER_W = 32,
    parameter int DIR_CNT = 4,
    parameter int DEF_DIR = 0,
    parameter int CNT_W   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [DATA_W-1:0]          pkt_data_i,
    input  logic [EMPTY_W-1:0]         pkt_empty_i,
    input  logic [TUSER_W-1:0]         pkt_tuser_i,
    input  logic                       pkt_sop_i,
    input  logic                       pkt_eop_i,
    input  logic                       pkt_val_i,
    output logic                       pkt_ready_o,
    input  logic [DIR_CNT-1:0]         dir_mask_i,
    input  logic [DIR_CNT-1:0]         lossy_mask_i,
    input  logic                       cnt_clr_i,
    output logic [DIR_CNT*DATA_W-1:0]  pkt_data_o,
    output logic [DIR_CNT*EMPTY_W-1:0] pkt_empty_o,
    output logic [DIR_CNT*TUSER_W-1:0] pkt_tuser_o,
    output logic [DIR_CNT-1:0]         pkt_sop_o,
    output logic [DIR_CNT-1:0]         pkt_eop_o,
    output logic [DIR_CNT-1:0]         pkt_val_o,
    input  logic [DIR_CNT-1:0]         pkt_ready_i,
    output logic [DIR_CNT*CNT_W-1:0]   pkt_cnt_o,
    output logic [DIR_CNT*CNT_W-1:0]   drop_cnt_o,
    output logic                       orphan_o
);

    localparam int WORD_W = word_width(DATA_W, EMPTY_W, TUSER_W);
    localparam logic [DIR_CNT-1:0] DEF_MASK = {{(DIR_CNT-1){1'b0}}, 1'b1} << DEF_DIR;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [DIR_CNT-1:0]  r_act_mask;
    logic                r_orphan;

    logic [DIR_CNT-1:0]  w_can_take;
    logic [DIR_CNT-1:0]  w_base;
    logic [DIR_CNT-1:0]  w_drop;
    logic [DIR_CNT-1:0]  w_eff;
    logic [DIR_CNT-1:0]  w_load;
    logic [DIR_CNT-1:0]  w_pkt_inc;
    logic [DIR_CNT-1:0]  w_drop_inc;
    logic                w_ready;
    logic                w_hs;
    logic                w_sop_hs;
    logic [WORD_W-1:0]   w_word_in;

    assign w_word_in = {pkt_data_i, pkt_empty_i, pkt_sop_i, pkt_eop_i, pkt_tuser_i};

    // Target resolution at sop: lossy directions that cannot take a word
    // right now are removed from the set instead of stalling the input.
    assign w_base = (dir_mask_i == '0) ? DEF_MASK : dir_mask_i;
    assign w_drop = w_base & lossy_mask_i & ~w_can_take;
    assign w_eff  = w_base & ~w_drop;

    always_comb begin
        w_ready = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (pkt_val_i && pkt_sop_i && (w_eff != '0))
                    w_ready = &(w_can_take | ~w_eff);
            end
            ST_PASS:  w_ready = &(w_can_take | ~r_act_mask);
            default:  w_ready = 1'b1;
        endcase
        if (!rst_n_i)
            w_ready = 1'b0;
    end

    assign pkt_ready_o = w_ready;
    assign w_hs        = pkt_val_i & w_ready;
    assign w_sop_hs    = w_hs & pkt_sop_i & (r_state == ST_IDLE);
    assign w_load      = w_sop_hs ? w_eff
                       : ((w_hs && (r_state == ST_PASS)) ? r_act_mask : '0);
    assign w_pkt_inc   = w_sop_hs ? w_eff  : '0;
    assign w_drop_inc  = w_sop_hs ? w_drop : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sop_hs && !pkt_eop_i)
                    w_state_nxt = (w_eff != '0) ? ST_PASS : ST_DISCARD;
            end
            ST_PASS, ST_DISCARD: begin
                if (w_hs && pkt_eop_i)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_act_mask <= '0;
            r_orphan   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_orphan <= w_hs & ~pkt_sop_i & (r_state == ST_IDLE);
            if (w_sop_hs)
                r_act_mask <= w_eff;
        end
    end

    assign orphan_o = r_orphan;

    for (genvar d = 0; d < DIR_CNT; d++) begin : g_dir
        logic [WORD_W-1:0] w_word_out;
        logic [CNT_W-1:0]  r_pkt_cnt;
        logic [CNT_W-1:0]  r_drop_cnt;

        eth_pkt_out_reg #(
            .WORD_W (WORD_W)
        ) u_out_reg (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .i_load     (w_load[d]),
            .i_word     (w_word_in),
            .i_ready    (pkt_ready_i[d]),
            .o_val      (pkt_val_o[d]),
            .o_word     (w_word_out),
            .o_can_take (w_can_take[d])
        );

        assign {pkt_data_o[d*DATA_W +: DATA_W],
                pkt_empty_o[d*EMPTY_W +: EMPTY_W],
                pkt_sop_o[d],
                pkt_eop_o[d],
                pkt_tuser_o[d*TUSER_W +: TUSER_W]} = w_word_out;

        // Clear has priority; counters wrap naturally.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_pkt_cnt  <= '0;
                r_drop_cnt <= '0;
            end else if (cnt_clr_i) begin
                r_pkt_cnt  <= '0;
                r_drop_cnt <= '0;
            end else begin
                if (w_pkt_inc[d])
                    r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                if (w_drop_inc[d])
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end

        assign pkt_cnt_o[d*CNT_W +: CNT_W]  = r_pkt_cnt;
        assign drop_cnt_o[d*CNT_W +: CNT_W] = r_drop_cnt;
    end

endmodule

// File: tb/tb_eth_rx_dispatch.sv
module tb_eth_rx_dispatch;

    localparam int DW = 64, EW = 3, TW = 32, ND = 4, CW = 32;
    localparam int WW = DW + EW + TW + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW-1:0]    pkt_data_i;
    logic [EW-1:0]    pkt_empty_i;
    logic [TW-1:0]    pkt_tuser_i;
    logic             pkt_sop_i, pkt_eop_i, pkt_val_i;
    logic             pkt_ready_o;
    logic [ND-1:0]    dir_mask_i, lossy_mask_i;
    logic             cnt_clr_i;
    logic [ND*DW-1:0] pkt_data_o;
    logic [ND*EW-1:0] pkt_empty_o;
    logic [ND*TW-1:0] pkt_tuser_o;
    logic [ND-1:0]    pkt_sop_o, pkt_eop_o, pkt_val_o;
    logic [ND-1:0]    pkt_ready_i;
    logic [ND*CW-1:0] pkt_cnt_o, drop_cnt_o;
    logic             orphan_o;

    int checks = 0;
    int errors = 0;
    int orph   = 0;
    int w;
    logic [WW-1:0] exp_q [ND][$];

    always #5 clk = ~clk;

    eth_rx_dispatch #(
        .DATA_W(DW), .EMPTY_W(EW), .TUSER_W(TW),
        .DIR_CNT(ND), .DEF_DIR(3), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .pkt_data_i(pkt_data_i), .pkt_empty_i(pkt_empty_i), .pkt_tuser_i(pkt_tuser_i),
        .pkt_sop_i(pkt_sop_i), .pkt_eop_i(pkt_eop_i), .pkt_val_i(pkt_val_i),
        .pkt_ready_o(pkt_ready_o),
        .dir_mask_i(dir_mask_i), .lossy_mask_i(lossy_mask_i), .cnt_clr_i(cnt_clr_i),
        .pkt_data_o(pkt_data_o), .pkt_empty_o(pkt_empty_o), .pkt_tuser_o(pkt_tuser_o),
        .pkt_sop_o(pkt_sop_o), .pkt_eop_o(pkt_eop_o), .pkt_val_o(pkt_val_o),
        .pkt_ready_i(pkt_ready_i),
        .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o), .orphan_o(orphan_o)
    );

    function automatic logic [WW-1:0] mk(input logic [DW-1:0] d, input logic sop, input logic eop);
        return {d, d[EW-1:0], sop, eop, d[TW-1:0] ^ 32'hA5A5_5A5A};
    endfunction

    function automatic logic [CW-1:0] pcnt(input int d);
        return pkt_cnt_o[d*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] dcnt(input int d);
        return drop_cnt_o[d*CW +: CW];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    // Present one word and hold it until the input handshake; returns the
    // number of cycles the input was stalled. Starts and ends at posedge+1.
    task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop, output int waits);
        pkt_data_i  = d;
        pkt_empty_i = d[EW-1:0];
        pkt_tuser_i = d[TW-1:0] ^ 32'hA5A5_5A5A;
        pkt_sop_i   = sop;
        pkt_eop_i   = eop;
        pkt_val_i   = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!pkt_ready_o) begin
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got stalled required handshake data %h", d);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        pkt_val_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        cnt_clr_i = 1'b1;
        idle(1);
        cnt_clr_i = 1'b0;
    endtask

    // Scoreboard monitor: each output handshake pops the direction's queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < ND; d++) begin
                if (pkt_val_o[d] && pkt_ready_i[d]) begin
                    logic [WW-1:0] act, exp;
                    act = {pkt_data_o[d*DW +: DW], pkt_empty_o[d*EW +: EW],
                           pkt_sop_o[d], pkt_eop_o[d], pkt_tuser_o[d*TW +: TW]};
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        errors++;
                        $display("FAIL out_dir%0d unexpected word got %h required none", d, act);
                    end else begin
                        exp = exp_q[d].pop_front();
                        if (act !== exp) begin
                            errors++;
                            $display("FAIL out_dir%0d word got %h required %h", d, act, exp);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) if (orphan_o) orph++;

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pkt_data_i = '0; pkt_empty_i = '0; pkt_tuser_i = '0;
        pkt_sop_i = 1'b1; pkt_eop_i = 1'b0; pkt_val_i = 1'b1;
        dir_mask_i = '0; lossy_mask_i = '0; cnt_clr_i = 1'b0;
        pkt_ready_i = 4'hF;

        // Reset state
        idle(3);
        chk("rst_ready", 64'(pkt_ready_o), 64'd0);
        chk("rst_val", 64'(pkt_val_o), 64'd0);
        chk("rst_orphan", 64'(orphan_o), 64'd0);
        chk("rst_pkt_cnt", 64'(|pkt_cnt_o), 64'd0);
        chk("rst_drop_cnt", 64'(|drop_cnt_o), 64'd0);
        pkt_val_i = 1'b0;
        pkt_sop_i = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // T1: unicast 3-word packet to dir 1
        dir_mask_i = 4'b0010;
        clr();
        for (int i = 0; i < 3; i++) begin
            exp_q[1].push_back(mk(64'h1111_0000_0000_0010 + 64'(i), i == 0, i == 2));
            send(64'h1111_0000_0000_0010 + 64'(i), i == 0, i == 2, w);
            chk("t1_nostall", 64'(w), 64'd0);
        end
        idle(3);
        chk("t1_pkt_cnt1", 64'(pcnt(1)), 64'd1);
        chk("t1_pkt_cnt0", 64'(pcnt(0)), 64'd0);

        // T2: multicast to 0 and 2, dir 2 stalls 2 cycles mid-packet
        dir_mask_i = 4'b0101;
        clr();
        for (int i = 0; i < 3; i++) begin
            exp_q[0].push_back(mk(64'h2222_0000_0000_0020 + 64'(i), i == 0, i == 2));
            exp_q[2].push_back(mk(64'h2222_0000_0000_0020 + 64'(i), i == 0, i == 2));
        end
        send(64'h2222_0000_0000_0020, 1'b1, 1'b0, w);
        chk("t2_w0_nostall", 64'(w), 64'd0);
        pkt_ready_i[2] = 1'b0;
        fork
            begin
                repeat (2) @(posedge clk);
                #1 pkt_ready_i[2] = 1'b1;
            end
        join_none
        send(64'h2222_0000_0000_0021, 1'b0, 1'b0, w);
        chk("t2_stall2", 64'(w), 64'd2);
        send(64'h2222_0000_0000_0022, 1'b0, 1'b1, w);
        chk("t2_w2_nostall", 64'(w), 64'd0);
        idle(3);
        chk("t2_pkt_cnt0", 64'(pcnt(0)), 64'd1);
        chk("t2_pkt_cnt2", 64'(pcnt(2)), 64'd1);
        chk("t2_pkt_cnt1", 64'(pcnt(1)), 64'd0);

        // T3: zero mask uses default dir 3; FSM stays IDLE after sop+eop
        dir_mask_i = 4'b0000;
        clr();
        exp_q[3].push_back(mk(64'h3333_0000_0000_0031, 1'b1, 1'b1));
        send(64'h3333_0000_0000_0031, 1'b1, 1'b1, w);
        chk("t3_latency", 64'(pkt_val_o), 64'h8);
        dir_mask_i = 4'b0001;
        exp_q[0].push_back(mk(64'h3333_0000_0000_0032, 1'b1, 1'b1));
        send(64'h3333_0000_0000_0032, 1'b1, 1'b1, w);
        idle(2);
        chk("t3_pkt_cnt3", 64'(pcnt(3)), 64'd1);
        chk("t3_pkt_cnt0", 64'(pcnt(0)), 64'd1);

        // T4: lossy dir 1 is full at sop -> dropped, dir 0 only, no stall
        pkt_ready_i[1] = 1'b0;
        dir_mask_i = 4'b0010;
        exp_q[1].push_back(mk(64'h4444_0000_0000_0040, 1'b1, 1'b1));
        send(64'h4444_0000_0000_0040, 1'b1, 1'b1, w);
        idle(1);
        clr();
        dir_mask_i = 4'b0011;
        lossy_mask_i = 4'b0010;
        exp_q[0].push_back(mk(64'h4444_0000_0000_0041, 1'b1, 1'b0));
        exp_q[0].push_back(mk(64'h4444_0000_0000_0042, 1'b0, 1'b1));
        send(64'h4444_0000_0000_0041, 1'b1, 1'b0, w);
        chk("t4_sop_nostall", 64'(w), 64'd0);
        send(64'h4444_0000_0000_0042, 1'b0, 1'b1, w);
        chk("t4_eop_nostall", 64'(w), 64'd0);
        idle(2);
        chk("t4_drop_cnt1", 64'(dcnt(1)), 64'd1);
        chk("t4_pkt_cnt0", 64'(pcnt(0)), 64'd1);
        chk("t4_pkt_cnt1", 64'(pcnt(1)), 64'd0);
        chk("t4_dir1_held", 64'(pkt_val_o), 64'h2);
        pkt_ready_i[1] = 1'b1;
        idle(2);

        // T5: only target is lossy and blocked -> DISCARD whole packet
        pkt_ready_i[1] = 1'b0;
        lossy_mask_i = 4'b0000;
        dir_mask_i = 4'b0010;
        exp_q[1].push_back(mk(64'h5555_0000_0000_0050, 1'b1, 1'b1));
        send(64'h5555_0000_0000_0050, 1'b1, 1'b1, w);
        idle(1);
        clr();
        lossy_mask_i = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            send(64'h5555_0000_0000_0051 + 64'(i), i == 0, i == 4, w);
            chk("t5_discard_rate", 64'(w), 64'd0);
        end
        idle(2);
        chk("t5_drop_cnt1", 64'(dcnt(1)), 64'd1);
        chk("t5_pkt_cnt1", 64'(pcnt(1)), 64'd0);
        chk("t5_no_output", 64'(pkt_val_o), 64'h2);
        lossy_mask_i = 4'b0000;
        pkt_ready_i[1] = 1'b1;
        idle(2);

        // T6: reset during word 2 of 4, remaining words become orphans
        dir_mask_i = 4'b0001;
        clr();
        exp_q[0].push_back(mk(64'h6666_0000_0000_0060, 1'b1, 1'b0));
        exp_q[0].push_back(mk(64'h6666_0000_0000_0061, 1'b0, 1'b0));
        send(64'h6666_0000_0000_0060, 1'b1, 1'b0, w);
        send(64'h6666_0000_0000_0061, 1'b0, 1'b0, w);
        @(negedge clk);
        #1;
        pkt_data_i = 64'h6666_0000_0000_0062;
        pkt_sop_i = 1'b0;
        pkt_eop_i = 1'b0;
        pkt_val_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_val", 64'(pkt_val_o), 64'd0);
        chk("t6_rst_ready", 64'(pkt_ready_o), 64'd0);
        chk("t6_rst_data", 64'(|pkt_data_o), 64'd0);
        chk("t6_rst_pkt_cnt0", 64'(pcnt(0)), 64'd0);
        pkt_val_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        orph = 0;
        send(64'h6666_0000_0000_0062, 1'b0, 1'b0, w);
        send(64'h6666_0000_0000_0063, 1'b0, 1'b1, w);
        idle(3);
        chk("t6_orphans", 64'(orph), 64'd2);
        chk("t6_pkt_cnt_all", 64'(|pkt_cnt_o), 64'd0);
        chk("t6_no_output", 64'(pkt_val_o), 64'd0);

        for (int d = 0; d < ND; d++)
            chk($sformatf("queue_empty_dir%0d", d), 64'(exp_q[d].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_dispatch.md
# eth_rx_dispatch

Parametrised receive-side packet dispatcher that steers each incoming packet to one or several of DIR_CNT output directions according to a per-packet direction mask. The mask is supplied by the direction resolver. The block sits between the rx engine and the consumers (CPU path, drop sink, future hardware paths). It adds multicast delivery, per-direction lossy mode, a default direction, and per-direction packet/drop counters, with one registered output stage per direction.

## Interface
Parameters:
- DATA_W, 64, data bus width
- EMPTY_W, 3, empty-byte field width (log2(DATA_W/8))
- TUSER_W, 32, sideband width, carried unchanged with every word
- DIR_CNT, 4, number of output directions (2..16)
- DEF_DIR, 0, direction used when the sampled mask is all-zero
- CNT_W, 32, counter width

Ports:
- clk_i  in  1  single clock for all logic
- rst_n_i  in  1  reset: asynchronous, active-low
- pkt_data_i / pkt_empty_i / pkt_tuser_i  in  DATA_W / EMPTY_W / TUSER_W  input word
- pkt_sop_i, pkt_eop_i, pkt_val_i  in  1 each  input framing and valid
- pkt_ready_o  out  1  input ready
- dir_mask_i  in  DIR_CNT  target directions, sampled on the sop handshake
- lossy_mask_i  in  DIR_CNT  per-direction lossy enable, sampled on the sop handshake
- cnt_clr_i  in  1  synchronous clear of all counters
- pkt_data_o / pkt_empty_o / pkt_tuser_o  out  DIR_CNT×(DATA_W / EMPTY_W / TUSER_W)  per-direction word
- pkt_sop_o, pkt_eop_o, pkt_val_o  out  DIR_CNT each  per-direction framing and valid
- pkt_ready_i  in  DIR_CNT  per-direction ready
- pkt_cnt_o, drop_cnt_o  out  DIR_CNT×CNT_W  per-direction delivered and dropped packet counts
- orphan_o  out  1  one-cycle pulse when a non-sop word is discarded in IDLE

## Operation
- The input handshake is `pkt_val_i & pkt_ready_o`. The output handshake for direction d is `pkt_val_o[d] & pkt_ready_i[d]`.
- can_take[d] = `~pkt_val_o[d] | pkt_ready_i[d]`.
- FSM states are IDLE, PASS and DISCARD.
- IDLE, non-sop valid word:
  - `pkt_ready_o = 1`; the word is consumed and discarded.
  - orphan_o pulses.
- IDLE, sop word:
  - base = `dir_mask_i`, or `1<<DEF_DIR` if `dir_mask_i == 0`.
  - eff = `base & ~(lossy_mask_i & ~can_take)`.
  - Each direction in base that is removed by the lossy term gets drop_cnt +1 on the handshake.
  - If eff ≠ 0: `pkt_ready_o = &(can_take | ~eff)`. On handshake, eff is latched as act_mask, the word is loaded into the output registers of all act_mask directions, and pkt_cnt +1 for each of them.
    - If eop is also set (single-word packet), the FSM stays in IDLE; otherwise it moves to PASS.
  - If eff == 0: `pkt_ready_o = 1` and the word is consumed. The FSM moves to DISCARD, or stays in IDLE if eop is set.
- PASS:
  - `pkt_ready_o = &(can_take | ~act_mask)`.
  - Each accepted word is loaded into all act_mask directions.
  - eop handshake → IDLE.
  - A sop arriving in PASS is treated as data (no resync).
- DISCARD: `pkt_ready_o = 1`, words are consumed without output, eop handshake → IDLE.
- Lossy applies only at sop. A lossy direction that stalls mid-packet backpressures like a normal direction.
- Directions not in act_mask never stall the input.
- Counters:
  - Wrap modulo 2^CNT_W.
  - cnt_clr_i wins over a same-cycle increment.
  - A direction in both the pkt_cnt and drop_cnt sets in the same cycle is impossible by construction.

## Timing
- Latency is 1 cycle from input handshake to pkt_val_o on the targeted directions.
- Full throughput: one word per cycle while all act_mask directions are ready.
- `pkt_ready_o` is combinational from state, pkt_val_i/pkt_sop_i, the masks, pkt_val_o and pkt_ready_i. It does not depend on data.
- Reset values:
  - State IDLE, act_mask 0.
  - All pkt_val_o 0; data, empty, tuser, sop, eop outputs 0.
  - All counters 0, orphan_o 0.
  - pkt_ready_o is forced 0 while rst_n_i is low.
- Reset mid-packet: output registers are cleared immediately (a partial packet is lost, with no eop). After release, the block resumes in IDLE, and remaining words of the cut packet are counted as orphans.

## Structure
- Package eth_rx_dispatch_pkg holds the FSM state enum (IDLE/PASS/DISCARD) and a word struct {data, empty, sop, eop, tuser} parametrised through typedef widths.
- One sub-module, eth_pkt_out_reg: single-entry output register with val/ready, load enable and can_take output. It is generated DIR_CNT times.
- Counters and the FSM live in the top.

## Test plan
- DIR_CNT=4, 3-word packet, mask 4'b0010, all ready → words on dir 1 only, cycles N+1..N+3; pkt_cnt[1]=1.
- Mask 4'b0101, dir 2 ready deasserted 2 cycles mid-packet → input stalls 2 cycles; dirs 0 and 2 receive identical 3-word streams.
- Mask 0, DEF_DIR=3, single-word sop+eop → delivered on dir 3, FSM stays IDLE, pkt_cnt[3]=1.
- Mask 4'b0011, lossy 4'b0010, dir 1 full and not ready at sop → dir 0 only; drop_cnt[1]=1, no stall.
- Mask 4'b0010, lossy 4'b0010, dir 1 blocked → DISCARD, 5 words consumed at 1/cycle, no outputs, drop_cnt[1]=1.
- rst_n_i low during word 2 of 4, then two non-sop words → outputs cleared, orphan_o pulses twice, counters 0.
